// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants, state encoding and immediate decoders for the EX-stage
// control-transfer resolution controller.
package branch_resolve_ctrl_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{21{inst[31]}}, inst[30:20]};
    endfunction

endpackage

// File: rtl/branch_cmp_unit.sv
// Combinational branch condition evaluator: equality and signed/unsigned
// less-than, selected by funct3.
module branch_cmp_unit
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign ltu_s = (a < b);

    // Select the branch condition; reserved funct3 codes are never taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq_s;
            F3_BNE:  taken = ~eq_s;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = ltu_s;
            F3_BGEU: taken = ~ltu_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/JAL/JALR resolution: redirects fetch on misprediction and
// flags misaligned targets. Counters are built only with BRANCH_STATS_EN.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [31:0]      ex_inst,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             misalign_excp,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    state_e          state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic            is_cti_s;
    logic            cmp_taken_s;
    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] actual_next_s;
    logic [XLEN-1:0] pred_next_s;
    logic            accept_s;
    logic            misalign_s;
    logic            mispred_s;

    branch_cmp_unit #(.XLEN(XLEN)) u_cmp (
        .funct3 (ex_inst[14:12]),
        .a      (rs1_data),
        .b      (rs2_data),
        .taken  (cmp_taken_s)
    );

    // Decode the control transfer and form its target
    always_comb begin
        is_cti_s = 1'b0;
        taken_s  = 1'b0;
        target_s = ex_pc + imm_b(ex_inst);
        case (ex_inst[6:0])
            OPC_BRANCH: begin
                is_cti_s = 1'b1;
                taken_s  = cmp_taken_s;
                target_s = ex_pc + imm_b(ex_inst);
            end
            OPC_JAL: begin
                is_cti_s = 1'b1;
                taken_s  = 1'b1;
                target_s = ex_pc + imm_j(ex_inst);
            end
            OPC_JALR: begin
                is_cti_s = 1'b1;
                taken_s  = 1'b1;
                target_s = (rs1_data + imm_i(ex_inst)) & ~32'd1;
            end
            default: begin
                is_cti_s = 1'b0;
                taken_s  = 1'b0;
            end
        endcase
    end

    assign ex_ready      = (state_q == S_IDLE);
    assign seq_pc_s      = ex_pc + 32'd4;
    assign actual_next_s = taken_s ? target_s : seq_pc_s;
    assign pred_next_s   = pred_taken ? pred_target : seq_pc_s;
    assign accept_s      = ex_valid & ex_ready & is_cti_s;
    assign misalign_s    = taken_s & target_s[1];
    assign mispred_s     = (actual_next_s != pred_next_s);

    // Next-state and registered-output logic of the redirect FSM
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        misalign_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && misalign_s) begin
                    flush_d    = 1'b1;
                    misalign_d = 1'b1;
                end else if (accept_s && mispred_s) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = actual_next_s;
                    flush_d          = 1'b1;
                    state_d          = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (redirect_ready && redirect_valid_q) begin
                    redirect_valid_d = 1'b0;
                    state_d          = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d          = S_IDLE;
                redirect_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            misalign_q       <= misalign_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign_excp  = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    // Saturating counters: misaligned transfers count as resolved, not mispredicted
    always_comb begin
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (accept_s && (branches_q != {CNT_W{1'b1}})) begin
            branches_d = branches_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            branches_d = branches_q;
        end
        if (accept_s && !misalign_s && mispred_s && (mispred_q != {CNT_W{1'b1}})) begin
            mispred_d = mispred_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mispred_d = mispred_q;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= {CNT_W{1'b0}};
            mispred_q  <= {CNT_W{1'b0}};
        end else begin
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;
`else
    assign stat_branches = {CNT_W{1'b0}};
    assign stat_mispred  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl plus hand-written
// sequences for hold, handshake and asynchronous reset behaviour.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        misalign_excp;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int checks;
    int failures;

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_inst        (ex_inst),
        .ex_pc          (ex_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .misalign_excp  (misalign_excp),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pt;
        logic [31:0] ptgt;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        ex_valid    = 1'b1;
        ex_inst     = v.inst;
        ex_pc       = v.pc;
        rs1_data    = v.rs1;
        rs2_data    = v.rs2;
        pred_taken  = v.pt;
        pred_target = v.ptgt;
    endtask

    initial begin
        vec_t beq_v;
        vec_t jal_v;
        logic [31:0] exp_stat_br;
        logic [31:0] exp_stat_mp;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        ex_valid       = 1'b0;
        ex_inst        = 32'd0;
        ex_pc          = 32'd0;
        rs1_data       = 32'd0;
        rs2_data       = 32'd0;
        pred_taken     = 1'b0;
        pred_target    = 32'd0;
        redirect_ready = 1'b0;

        vecs[0]  = '{"beq_mispred",  enc_b(13'd16, 3'b000),        32'h100,  32'd5,        32'd5,        1'b0, 32'h0,        1'b1, 32'h110,  1'b0};
        vecs[1]  = '{"blt_correct",  enc_b(13'd32, 3'b100),        32'h200,  32'hFFFFFFFF, 32'd1,        1'b1, 32'h220,      1'b0, 32'h0,    1'b0};
        vecs[2]  = '{"bltu_mispred", enc_b(13'd32, 3'b110),        32'h200,  32'hFFFFFFFF, 32'd1,        1'b1, 32'h220,      1'b1, 32'h204,  1'b0};
        vecs[3]  = '{"jalr_misal",   enc_i(12'd0),                 32'h300,  32'h203,      32'd0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b1};
        vecs[4]  = '{"bne_nt_ok",    enc_b(-13'sd8, 3'b001),       32'h400,  32'd3,        32'd3,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[5]  = '{"bge_eq_ok",    enc_b(13'd64, 3'b101),        32'h500,  32'hFFFFFFFB, 32'hFFFFFFFB, 1'b1, 32'h540,      1'b0, 32'h0,    1'b0};
        vecs[6]  = '{"bgeu_nt_ok",   enc_b(13'd8, 3'b111),         32'h600,  32'd1,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[7]  = '{"jal_back_ok",  enc_j(-21'sd256),             32'h1000, 32'd0,        32'd0,        1'b1, 32'hF00,      1'b0, 32'h0,    1'b0};
        vecs[8]  = '{"jal_mispred",  enc_j(21'h800),               32'h1000, 32'd0,        32'd0,        1'b0, 32'h0,        1'b1, 32'h1800, 1'b0};
        vecs[9]  = '{"f3_010_nt",    enc_b(13'd16, 3'b010),        32'h700,  32'd9,        32'd9,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[10] = '{"non_cti",      32'h00108093,                 32'h800,  32'd0,        32'd0,        1'b1, 32'h99990000, 1'b0, 32'h0,    1'b0};

        #12;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_misalign", {31'd0, misalign_excp}, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            ex_valid = 1'b0;
            check({vecs[i].name, "_rv"}, {31'd0, redirect_valid}, {31'd0, vecs[i].exp_rv});
            check({vecs[i].name, "_flush"}, {31'd0, flush}, {31'd0, vecs[i].exp_rv | vecs[i].exp_mis});
            check({vecs[i].name, "_misal"}, {31'd0, misalign_excp}, {31'd0, vecs[i].exp_mis});
            check({vecs[i].name, "_ready"}, {31'd0, ex_ready}, {31'd0, ~vecs[i].exp_rv});
            if (vecs[i].exp_rv) begin
                check({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].exp_pc);
                redirect_ready = 1'b1;
            end
            step();
            redirect_ready = 1'b0;
            check({vecs[i].name, "_rv_after"}, {31'd0, redirect_valid}, 32'd0);
            check({vecs[i].name, "_flush_after"}, {31'd0, flush}, 32'd0);
            check({vecs[i].name, "_misal_after"}, {31'd0, misalign_excp}, 32'd0);
            check({vecs[i].name, "_ready_after"}, {31'd0, ex_ready}, 32'd1);
        end

`ifdef BRANCH_STATS_EN
        exp_stat_br = 32'd10;
        exp_stat_mp = 32'd3;
`else
        exp_stat_br = 32'd0;
        exp_stat_mp = 32'd0;
`endif
        check("stat_branches", stat_branches, exp_stat_br);
        check("stat_mispred", stat_mispred, exp_stat_mp);

        // Redirect held for three cycles, then a CTI presented in the handshake cycle
        beq_v = vecs[0];
        jal_v = vecs[8];
        drive(beq_v);
        step();
        ex_valid = 1'b0;
        check("hold_c1_rv", {31'd0, redirect_valid}, 32'd1);
        check("hold_c1_flush", {31'd0, flush}, 32'd1);
        check("hold_c1_ready", {31'd0, ex_ready}, 32'd0);
        for (int c = 2; c <= 3; c++) begin
            step();
            check($sformatf("hold_c%0d_rv", c), {31'd0, redirect_valid}, 32'd1);
            check($sformatf("hold_c%0d_rpc", c), redirect_pc, 32'h110);
            check($sformatf("hold_c%0d_flush", c), {31'd0, flush}, 32'd0);
            check($sformatf("hold_c%0d_ready", c), {31'd0, ex_ready}, 32'd0);
        end
        step();
        check("hold_c4_ready", {31'd0, ex_ready}, 32'd0);
        check("hold_c4_rpc", redirect_pc, 32'h110);
        redirect_ready = 1'b1;
        drive(jal_v);
        step();
        redirect_ready = 1'b0;
        check("hs_rv_drop", {31'd0, redirect_valid}, 32'd0);
        check("hs_no_accept_flush", {31'd0, flush}, 32'd0);
        check("hs_ready", {31'd0, ex_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
        check("late_accept_rv", {31'd0, redirect_valid}, 32'd1);
        check("late_accept_rpc", redirect_pc, 32'h1800);
        check("late_accept_flush", {31'd0, flush}, 32'd1);
        redirect_ready = 1'b1;
        step();
        check("late_done_rv", {31'd0, redirect_valid}, 32'd0);

        // redirect_ready with nothing pending is ignored
        step();
        redirect_ready = 1'b0;
        check("idle_rr_rv", {31'd0, redirect_valid}, 32'd0);
        check("idle_rr_ready", {31'd0, ex_ready}, 32'd1);

        // Asynchronous reset while holding a redirect
        drive(beq_v);
        step();
        ex_valid = 1'b0;
        check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("async_rst_rpc", redirect_pc, 32'd0);
        check("async_rst_ready", {31'd0, ex_ready}, 32'd1);
        check("async_rst_stat", stat_branches, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, ex_ready}, 32'd1);
        check("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
